axi4_ram_slave: RTL
===================

AXI4_RAM_SLAVE -- requirements
Module: axi4_ram_slave

Interface
REQ-001 SHALL have parameter ASIZE, default 29, byte address width.
REQ-002 SHALL have parameter AXI_DSIZE, default 256, data width in bits (power of 2, at least 8).
REQ-003 SHALL have parameter IDSIZE, default 4, AXI ID width.
REQ-004 SHALL have parameter BURST_LEN_SIZE, default 9, width of axi_awlen/axi_arlen.
REQ-005 SHALL have parameter DEPTH_LOG, default 10, log2 of RAM depth in AXI_DSIZE words.
REQ-006 SHALL have ports: axi_aclk in 1, the single clock; axi_reset in 1, reset (synchronous, active-high).
REQ-007 SHALL have write-address ports: axi_awid in IDSIZE; axi_awaddr in ASIZE; axi_awlen in BURST_LEN_SIZE; axi_awsize in 3; axi_awburst in 2; axi_awvalid in 1; axi_awready out 1.
REQ-008 SHALL have write-data ports: axi_wdata in AXI_DSIZE; axi_wstrb in AXI_DSIZE/8; axi_wlast in 1; axi_wvalid in 1; axi_wready out 1.
REQ-009 SHALL have write-response ports: axi_bid out IDSIZE; axi_bresp out 2; axi_bvalid out 1; axi_bready in 1.
REQ-010 SHALL have read-address ports: axi_arid in IDSIZE; axi_araddr in ASIZE; axi_arlen in BURST_LEN_SIZE; axi_arsize in 3; axi_arburst in 2; axi_arvalid in 1; axi_arready out 1.
REQ-011 SHALL have read-data ports: axi_rid out IDSIZE; axi_rdata out AXI_DSIZE; axi_rresp out 2; axi_rlast out 1; axi_rvalid out 1; axi_rready in 1.

Function
REQ-012 SHALL be an AXI4 slave backed by a 2^DEPTH_LOG x AXI_DSIZE two-port RAM, the responder for the VDMA write and read masters.
REQ-013 SHALL derive the word address as addr[ASIZE-1:log2(AXI_DSIZE/8)] modulo 2^DEPTH_LOG; all bursts SHALL be treated as INCR; axsize and axburst are ignored.
REQ-014 SHALL increment the word address by 1 per beat, wrapping from 2^DEPTH_LOG-1 to 0.
REQ-015 Write FSM SHALL have states W_IDLE, W_DATA and W_RESP.
REQ-016 In W_IDLE, axi_awready=1; an AW handshake SHALL latch id, address and len+1, then go to W_DATA.
REQ-017 In W_DATA, axi_wready=1; each W handshake SHALL write the bytes enabled by axi_wstrb and decrement the beat count.
REQ-018 The final counted beat SHALL move the FSM to W_RESP; burst length is set by the beat counter, not by axi_wlast.
REQ-019 An axi_wlast value that disagrees with the beat counter on any beat SHALL latch bresp=2'b10 (SLVERR); otherwise bresp=2'b00.
REQ-020 In W_RESP, axi_bvalid=1 with the latched bid/bresp until axi_bready, then W_IDLE; this gives 1-cycle AW-to-WREADY latency.
REQ-021 Read FSM SHALL have states R_IDLE and R_DATA; in R_IDLE axi_arready=1 and an AR handshake latches id, address and len+1.
REQ-022 The RAM read port SHALL be synchronous; the first axi_rvalid SHALL assert 2 cycles after the AR handshake.
REQ-023 Read data SHALL advance when (!axi_rvalid || axi_rready), sustaining one beat per cycle under continuous axi_rready.
REQ-024 axi_rdata, axi_rlast and axi_rid SHALL hold stable while axi_rvalid=1 and axi_rready=0.
REQ-025 axi_rlast SHALL equal 1 on exactly the final beat; axi_rresp SHALL be 2'b00.
REQ-026 After the last beat handshake, the read FSM SHALL return to R_IDLE in the next cycle.
REQ-027 Read and write channels SHALL operate concurrently; a same-cycle read and write to one word SHALL return the old data (read-first).
REQ-028 len=0 SHALL mean a single beat; len=2^BURST_LEN_SIZE-1 SHALL be supported without counter overflow.

Reset
REQ-029 While axi_reset=1, both FSMs SHALL be IDLE and axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid and axi_rlast SHALL be 0.
REQ-030 While axi_reset=1, bresp, rresp, bid and rid SHALL be 0.
REQ-031 Reset mid-burst SHALL abandon the burst without a response; RAM contents SHALL NOT be cleared.
REQ-032 awready and arready SHALL go to 1 in the first cycle after reset deasserts.

Structure
REQ-033 The write and read FSM state enums and the BRESP/RRESP codes (OKAY=0, SLVERR=2) SHALL live in shared package axi4_slave_pkg.
REQ-034 The RAM SHALL be one sub-module, tdp_byte_ram: one byte-enable write port, one synchronous read port, read-first behaviour.

Verification
REQ-035 Bench SHALL cover: AW addr=0x40 (AXI_DSIZE=256), len=3, 4 beats with full wstrb, wlast on beat 4 -> bresp=0; AR same address and len -> 4 matching beats, rlast on beat 4.
REQ-036 Bench SHALL cover: wstrb=0x0000_000F on word 5 pre-filled with all-ones -> readback has bytes 0-3 new and the rest 0xFF.
REQ-037 Bench SHALL cover: axi_rready toggling 1,0,0,1 during an 8-beat read -> no lost or duplicated beats and rdata stable while stalled.
REQ-038 Bench SHALL cover: write len=3 with wlast on beat 2 -> 4 beats accepted, bresp=2'b10.
REQ-039 Bench SHALL cover: burst starting at word 2^DEPTH_LOG-2 with len=3 -> words 1022, 1023, 0, 1 written (DEPTH_LOG=10).
REQ-040 Bench SHALL cover: axi_reset pulse during W_DATA beat 2 -> all readies and valids 0 during reset, awready=1 in the next cycle, no axi_bvalid issued.

Source files
------------

// File: rtl/axi4_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_slave_pkg
//  Purpose  : Shared state encodings and AXI response codes for the AXI4
//             RAM slave and its helpers.
//  Revision : 1.0 - initial release
// ============================================================================
package axi4_slave_pkg;

   // Write channel sequencing: accept address, absorb beats, return response
   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_e;

   // Read channel sequencing: accept address, stream beats
   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_e;

   // AXI BRESP/RRESP encodings used by this slave
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/tdp_byte_ram.sv
`default_nettype none
// ============================================================================
//  Module   : tdp_byte_ram
//  Purpose  : Two-port RAM with a byte-enabled write port and a registered,
//             enable-gated read port. A read and write to the same word in
//             the same cycle returns the previous contents (read-first).
//  Revision : 1.0 - initial release
// ============================================================================
module tdp_byte_ram #(
   parameter int DATA_W = 256,
   parameter int ADDR_W = 10
) (
   input  logic                  clk_i,
   input  logic [ADDR_W-1:0]     wr_addr_i,
   input  logic [DATA_W-1:0]     wr_data_i,
   input  logic [DATA_W/8-1:0]   wr_be_i,
   input  logic                  rd_en_i,
   input  logic [ADDR_W-1:0]     rd_addr_i,
   output logic [DATA_W-1:0]     rd_data_o
);

   localparam int NBYTES = DATA_W / 8;
   localparam int DEPTH  = 1 << ADDR_W;

   logic [NBYTES-1:0][7:0] mem_q [0:DEPTH-1];
   logic [DATA_W-1:0]      rd_data_q;

   // Byte-enabled write; bytes whose enable is low keep their old value
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < NBYTES; b++) begin
         if (wr_be_i[b]) begin
            mem_q[wr_addr_i][b] <= wr_data_i[b*8 +: 8];
         end
      end
   end

   // Registered read; holds its output when not enabled so a stalled
   // consumer sees stable data. Sampling before the same-edge write lands
   // gives read-first behaviour.
   always_ff @(posedge clk_i) begin
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/axi4_ram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : axi4_ram_slave
//  Purpose  : AXI4 slave backed by a 2^DEPTH_LOG x AXI_DSIZE RAM. Every burst
//             is handled as INCR with a word-granular address that wraps at
//             the end of the RAM. Independent write and read engines.
//  Revision : 1.0 - initial release
// ============================================================================
module axi4_ram_slave
   import axi4_slave_pkg::*;
#(
   parameter int ASIZE          = 29,
   parameter int AXI_DSIZE      = 256,
   parameter int IDSIZE         = 4,
   parameter int BURST_LEN_SIZE = 9,
   parameter int DEPTH_LOG      = 10
) (
   input  logic                      axi_aclk,
   input  logic                      axi_reset,
   // write address
   input  logic [IDSIZE-1:0]         axi_awid,
   input  logic [ASIZE-1:0]          axi_awaddr,
   input  logic [BURST_LEN_SIZE-1:0] axi_awlen,
   input  logic [2:0]                axi_awsize,
   input  logic [1:0]                axi_awburst,
   input  logic                      axi_awvalid,
   output logic                      axi_awready,
   // write data
   input  logic [AXI_DSIZE-1:0]      axi_wdata,
   input  logic [AXI_DSIZE/8-1:0]    axi_wstrb,
   input  logic                      axi_wlast,
   input  logic                      axi_wvalid,
   output logic                      axi_wready,
   // write response
   output logic [IDSIZE-1:0]         axi_bid,
   output logic [1:0]                axi_bresp,
   output logic                      axi_bvalid,
   input  logic                      axi_bready,
   // read address
   input  logic [IDSIZE-1:0]         axi_arid,
   input  logic [ASIZE-1:0]          axi_araddr,
   input  logic [BURST_LEN_SIZE-1:0] axi_arlen,
   input  logic [2:0]                axi_arsize,
   input  logic [1:0]                axi_arburst,
   input  logic                      axi_arvalid,
   output logic                      axi_arready,
   // read data
   output logic [IDSIZE-1:0]         axi_rid,
   output logic [AXI_DSIZE-1:0]      axi_rdata,
   output logic [1:0]                axi_rresp,
   output logic                      axi_rlast,
   output logic                      axi_rvalid,
   input  logic                      axi_rready
);

   localparam int STRB_W   = AXI_DSIZE / 8;
   localparam int BYTE_LSB = $clog2(STRB_W);
   // One extra bit so len = 2^BURST_LEN_SIZE-1 plus one still fits
   localparam int CNT_W    = BURST_LEN_SIZE + 1;

   // Size and burst type are not used: every burst is word-sized INCR
   logic w_unused_sideband;
   assign w_unused_sideband = ^{axi_awsize, axi_awburst, axi_arsize, axi_arburst};

   // ---------------------------------------------------------------------
   // Write engine
   // ---------------------------------------------------------------------
   wr_state_e              wstate_q, wstate_d;
   logic [IDSIZE-1:0]      wid_q,    wid_d;
   logic [DEPTH_LOG-1:0]   waddr_q,  waddr_d;
   logic [CNT_W-1:0]       wcnt_q,   wcnt_d;
   logic                   werr_q,   werr_d;

   logic                   w_aw_fire;
   logic                   w_w_fire;
   logic                   w_last_beat;
   logic [DEPTH_LOG-1:0]   w_aw_word;

   // Handshake outputs are forced low while reset is held, including the
   // first reset cycle before the state registers have been cleared.
   assign axi_awready = (wstate_q == W_IDLE) && !axi_reset;
   assign axi_wready  = (wstate_q == W_DATA) && !axi_reset;
   assign axi_bvalid  = (wstate_q == W_RESP) && !axi_reset;
   assign axi_bid     = axi_reset ? '0 : wid_q;
   assign axi_bresp   = (werr_q && !axi_reset) ? RESP_SLVERR : RESP_OKAY;

   assign w_aw_fire   = axi_awvalid && axi_awready;
   assign w_w_fire    = axi_wvalid  && axi_wready;
   assign w_last_beat = (wcnt_q == CNT_W'(1));
   assign w_aw_word   = DEPTH_LOG'(axi_awaddr >> BYTE_LSB);

   // Write next-state: the beat counter alone decides the burst end; wlast
   // is only compared against it to flag a protocol error.
   always_comb begin
      wstate_d = wstate_q;
      wid_d    = wid_q;
      waddr_d  = waddr_q;
      wcnt_d   = wcnt_q;
      werr_d   = werr_q;
      case (wstate_q)
         W_IDLE: begin
            if (w_aw_fire) begin
               wid_d    = axi_awid;
               waddr_d  = w_aw_word;
               wcnt_d   = {1'b0, axi_awlen} + CNT_W'(1);
               werr_d   = 1'b0;
               wstate_d = W_DATA;
            end
         end
         W_DATA: begin
            if (w_w_fire) begin
               waddr_d = waddr_q + DEPTH_LOG'(1);
               wcnt_d  = wcnt_q - CNT_W'(1);
               if (axi_wlast != w_last_beat) begin
                  werr_d = 1'b1;
               end
               if (w_last_beat) begin
                  wstate_d = W_RESP;
               end
            end
         end
         W_RESP: begin
            if (axi_bready) begin
               wstate_d = W_IDLE;
            end
         end
         default: wstate_d = W_IDLE;
      endcase
   end

   // Write state register
   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         wstate_q <= W_IDLE;
         wid_q    <= '0;
         waddr_q  <= '0;
         wcnt_q   <= '0;
         werr_q   <= 1'b0;
      end else begin
         wstate_q <= wstate_d;
         wid_q    <= wid_d;
         waddr_q  <= waddr_d;
         wcnt_q   <= wcnt_d;
         werr_q   <= werr_d;
      end
   end

   // ---------------------------------------------------------------------
   // Read engine
   // ---------------------------------------------------------------------
   rd_state_e              rstate_q, rstate_d;
   logic [IDSIZE-1:0]      rid_q,    rid_d;
   logic [DEPTH_LOG-1:0]   raddr_q,  raddr_d;
   logic [CNT_W-1:0]       rleft_q,  rleft_d;   // beats still to fetch
   logic                   rvalid_q, rvalid_d;
   logic                   rlast_q,  rlast_d;

   logic                   w_ar_fire;
   logic                   w_r_adv;
   logic                   w_ram_re;
   logic [AXI_DSIZE-1:0]   w_ram_rdata;

   assign axi_arready = (rstate_q == R_IDLE) && !axi_reset;
   assign axi_rvalid  = rvalid_q && !axi_reset;
   assign axi_rlast   = rlast_q  && !axi_reset;
   assign axi_rid     = axi_reset ? '0 : rid_q;
   assign axi_rresp   = RESP_OKAY;
   // RAM output register doubles as the read data register; it only
   // reloads when the output slot advances, so data holds during a stall.
   assign axi_rdata   = w_ram_rdata;

   assign w_ar_fire   = axi_arvalid && axi_arready;
   assign w_r_adv     = !rvalid_q || axi_rready;

   // Read next-state: fetch one word whenever the output slot frees up
   always_comb begin
      rstate_d = rstate_q;
      rid_d    = rid_q;
      raddr_d  = raddr_q;
      rleft_d  = rleft_q;
      rvalid_d = rvalid_q;
      rlast_d  = rlast_q;
      w_ram_re = 1'b0;
      case (rstate_q)
         R_IDLE: begin
            if (w_ar_fire) begin
               rid_d    = axi_arid;
               raddr_d  = DEPTH_LOG'(axi_araddr >> BYTE_LSB);
               rleft_d  = {1'b0, axi_arlen} + CNT_W'(1);
               rstate_d = R_DATA;
            end
         end
         R_DATA: begin
            if (w_r_adv) begin
               if (rleft_q != '0) begin
                  w_ram_re = 1'b1;
                  raddr_d  = raddr_q + DEPTH_LOG'(1);
                  rleft_d  = rleft_q - CNT_W'(1);
                  rvalid_d = 1'b1;
                  rlast_d  = (rleft_q == CNT_W'(1));
               end else begin
                  rvalid_d = 1'b0;
                  rlast_d  = 1'b0;
               end
               if (rvalid_q && axi_rready && rlast_q) begin
                  rstate_d = R_IDLE;
               end
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   // Read state register
   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         rstate_q <= R_IDLE;
         rid_q    <= '0;
         raddr_q  <= '0;
         rleft_q  <= '0;
         rvalid_q <= 1'b0;
         rlast_q  <= 1'b0;
      end else begin
         rstate_q <= rstate_d;
         rid_q    <= rid_d;
         raddr_q  <= raddr_d;
         rleft_q  <= rleft_d;
         rvalid_q <= rvalid_d;
         rlast_q  <= rlast_d;
      end
   end

   // ---------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------
   tdp_byte_ram #(
      .DATA_W (AXI_DSIZE),
      .ADDR_W (DEPTH_LOG)
   ) u_ram (
      .clk_i     (axi_aclk),
      .wr_addr_i (waddr_q),
      .wr_data_i (axi_wdata),
      .wr_be_i   (axi_wstrb & {STRB_W{w_w_fire}}),
      .rd_en_i   (w_ram_re),
      .rd_addr_i (raddr_q),
      .rd_data_o (w_ram_rdata)
   );

endmodule
`default_nettype wire
